// File: rtl/dnn_argmax_fix_if.sv
// Score/result bundle between the inference engine and the argmax stage.
// The engine side (master) presents scores with a one-cycle start pulse;
// the argmax stage (slave) returns busy, a done pulse and the held result.
interface dnn_argmax_fix_if #(
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
);
  logic                                   start;
  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] scores;
  logic                                   busy;
  logic                                   done;
  logic [IDX_WIDTH-1:0]                   digit;
  logic [DATA_WIDTH-1:0]                  max_score;
  logic [DATA_WIDTH:0]                    margin;

  modport master (
    output start, scores,
    input  busy, done, digit, max_score, margin
  );

  modport slave (
    input  start, scores,
    output busy, done, digit, max_score, margin
  );
endinterface

// File: rtl/dnn_argmax_fix.sv
// Serial argmax over the signed output-layer scores of the MNIST engine.
// Scores are captured on start, scanned one per cycle with a single
// comparator, and the winning index/score are published with a done pulse.
// Optional feature macro: DNN_ARGMAX_MARGIN_EN builds runner-up tracking and
// drives margin = best - second; without it margin is tied to 0.
module dnn_argmax_fix #(
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,    // asynchronous, active-low
  input  logic              reset,  // synchronous soft clear, active-high
  dnn_argmax_fix_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DATA_WIDTH-1:0] score_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam score_t               MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  score_t               arr_q [NUM_CLASSES];
  score_t               arr_d [NUM_CLASSES];
  score_t               best_q, best_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [IDX_WIDTH-1:0] digit_q, digit_d;
  score_t               max_q, max_d;
  score_t               scan_s;

`ifdef DNN_ARGMAX_MARGIN_EN
  score_t               second_q, second_d;
  logic [DATA_WIDTH:0]  margin_q, margin_d;
`endif

  // Next-state and datapath update: capture, serial compare, publish.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    arr_d      = arr_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    digit_d    = digit_q;
    max_d      = max_q;
    scan_s     = arr_q[cnt_q];
`ifdef DNN_ARGMAX_MARGIN_EN
    second_d   = second_q;
    margin_d   = margin_q;
`endif

    if (reset) begin
      // Soft clear aborts any scan and wins over a coincident start.
      state_d = IDLE;
      digit_d = '0;
      max_d   = '0;
`ifdef DNN_ARGMAX_MARGIN_EN
      margin_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              arr_d[i] = score_t'(bus.scores[i]);
            end
            best_d     = score_t'(bus.scores[0]);
            best_idx_d = '0;
            cnt_d      = IDX_WIDTH'(1);
`ifdef DNN_ARGMAX_MARGIN_EN
            second_d   = MOST_NEG;
`endif
            state_d    = SCAN;
          end
        end

        SCAN: begin
          // Strict compare keeps the lower index on ties.
          if (scan_s > best_q) begin
            best_d     = scan_s;
            best_idx_d = cnt_q;
`ifdef DNN_ARGMAX_MARGIN_EN
            second_d   = best_q;
          end else if (scan_s > second_q) begin
            second_d   = scan_s;
`endif
          end
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DONE: begin
          digit_d = best_idx_q;
          max_d   = best_q;
`ifdef DNN_ARGMAX_MARGIN_EN
          // Sign-extended subtraction: best >= second, so never negative
          // and always fits in DATA_WIDTH+1 bits.
          margin_d = (DATA_WIDTH+1)'(best_q) - (DATA_WIDTH+1)'(second_q);
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      // NOTE: the score buffer is cleared on reset too, so every register
      // reads 0 while reset is held rather than leaving stale captures.
      for (int i = 0; i < NUM_CLASSES; i++) begin
        arr_q[i] <= '0;
      end
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      digit_q    <= '0;
      max_q      <= '0;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q   <= '0;
      margin_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q    <= state_d;
      arr_q      <= arr_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q   <= second_d;
      margin_q   <= margin_d;
`endif
    end
  end

  // busy stays high through the done cycle; a new start is still accepted
  // then because the FSM is already back in IDLE.
  assign bus.busy      = (state_q != IDLE) | done_q;
  assign bus.done      = done_q;
  assign bus.digit     = digit_q;
  assign bus.max_score = max_q;
`ifdef DNN_ARGMAX_MARGIN_EN
  assign bus.margin    = margin_q;
`else
  assign bus.margin    = '0;
`endif

endmodule

// File: doc/dnn_argmax_fix.md
# dnn_argmax_fix

Post-processing stage downstream of the fixed-point MNIST inference engine. Captures the ten signed output-layer scores when the engine signals completion, then scans them serially to find the winning class. Produces the predicted digit, the winning score and, optionally, the confidence margin over the runner-up. The scan is sequential so one comparator serves any class count.

## Interface
- DATA_WIDTH, 15, score width, signed two's complement
- NUM_CLASSES, 10, number of scores, must be ≥ 2
- IDX_WIDTH, 4, width of the class index, must satisfy 2^IDX_WIDTH ≥ NUM_CLASSES
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reset  in  1  synchronous soft clear, active-high; takes priority over start
- start  in  1  one-cycle pulse; connected to the engine's done output
- scores  in  DATA_WIDTH × [NUM_CLASSES-1:0]  signed scores, valid in the cycle start is high
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when the result registers update
- digit  out  IDX_WIDTH  index of the maximum score
- max_score  out  DATA_WIDTH  signed winning score
- margin  out  DATA_WIDTH+1  unsigned (max_score − runner-up score)

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1:
  - Latch all scores into an internal array.
  - Set best=scores[0], best_idx=0, cnt=1, second=most-negative value.
  - Go to SCAN.
- IDLE, start=0: stay in IDLE.
- SCAN: one element per cycle, s=arr[cnt].
  - If s > best (signed, strict): second←best, best←s, best_idx←cnt.
  - Else if s > second: second←s.
  - Ties keep the lower index.
  - When cnt==NUM_CLASSES-1: go to DONE. Otherwise cnt←cnt+1.
- DONE:
  - Drive digit←best_idx, max_score←best, margin←best−second.
  - Assert done for one cycle.
  - Go to IDLE.
- margin is computed at DATA_WIDTH+1 bits. It never overflows and is never negative.
- start while busy (SCAN or DONE) is ignored; no queuing.
- reset=1 on any edge:
  - Go to IDLE and clear all outputs to 0.
  - Any scan in progress is aborted and done is not asserted.
  - A start in the same cycle is ignored.
- rst low:
  - All registers and outputs are 0 immediately.
  - The FSM is in IDLE.
- digit, max_score and margin hold their value between done pulses.

## Timing
- Reset values: busy=0, done=0, digit=0, max_score=0, margin=0, state=IDLE.
- Cycle numbering: start is sampled at edge E0.
  - busy is high from E0 through the edge where done rises.
  - SCAN lasts NUM_CLASSES-1 cycles (E1..E9 for 10 classes).
  - done and the new results appear after edge E10, i.e. latency is NUM_CLASSES cycles.
- busy falls and done falls one cycle after done rises. A new start is accepted in that same cycle (E11).
- Throughput: one classification every NUM_CLASSES+1 cycles.
- Scores are sampled only at E0. The engine may change them afterwards.

## Configuration
- Macro: DNN_ARGMAX_MARGIN_EN.
- Defined:
  - The second-best register and its compare are built.
  - margin behaves as described above.
- Undefined:
  - Runner-up tracking is not synthesized.
  - margin is tied to 0 at all times.
  - digit, max_score, done and busy are unaffected.

## Test plan
- Reset: hold rst low mid-scan. All outputs are 0 and busy=0 immediately; after release, no done pulse occurs.
- Distinct scores: scores[i]=i*0x100, except scores[7]=0x1FFF. done occurs 10 cycles after start with digit=7, max_score=0x1FFF, margin=0x1FFF−0x0900=0x16FF.
- Tie: scores[2]=scores[5]=0x0800, others 0. Result is digit=2, max_score=0x0800, margin=0.
- All negative: scores[i]=−100−i. Result is digit=0, max_score=−100, margin=1.
- Extremes:
  - scores[9]=0x3FFF (16383), scores[0]=0x4000 (−16384), others −16384.
  - Result is digit=9, margin=32767 (16-bit, no wrap).
  - Without the macro, margin=0.
- Control:
  - A start pulse at E4 of a scan is ignored: exactly one done, for the first score set.
  - reset=1 at E5 of a scan: no done, and outputs are cleared.
  - A start at E11 is accepted.
